// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: single-byte register I2C initiator on open-drain pads.
// Write: S dev+W reg data P.  Read: S dev+W reg Sr dev+R data NACK P.
// Ports: wb_clk_i/wb_rst_i (sync, active-high); cmd_* request with
//   cmd_valid/cmd_ready; rsp_valid pulse with rsp_rdata/rsp_nack; busy;
//   scl_i/scl_oeb, sda_i/sda_oeb pads (oeb=0 pulls low, 1 releases).
// Build option: I2C_CLK_STRETCH_EN honours target clock stretching on SCL.
module i2c_master_ctrl #(
    parameter int unsigned QDIV = 100
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_dev,
    input  logic [7:0] cmd_reg,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       busy,
    input  logic       scl_i,
    output logic       scl_oeb,
    input  logic       sda_i,
    output logic       sda_oeb
);

    localparam logic [15:0] CNT_MAX = 16'(QDIV - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_DEVW,
        S_REG,
        S_WDATA,
        S_RSTART,
        S_DEVR,
        S_RDATA,
        S_STOP
    } state_t;

    state_t      state_q, state_d;
    state_t      byte_next;
    logic [2:0]  qtr_q, qtr_d;
    logic [3:0]  bit_q, bit_d;
    logic [15:0] cnt_q, cnt_d;
    logic        rw_q, rw_d;
    logic [6:0]  dev_q, dev_d;
    logic [7:0]  reg_q, reg_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        nack_q, nack_d;
    logic        busy_q, busy_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        scl_oeb_q, scl_oeb_d;
    logic        sda_oeb_q, sda_oeb_d;
    logic        tick;
    logic        stall;
    logic [7:0]  tx_byte;
    logic        tx_bit;

`ifdef I2C_CLK_STRETCH_EN
    // SCL released but still low: a target is stretching, so the
    // quarter timer waits and the high phase starts at the real rise.
    assign stall = scl_oeb_q & ~scl_i;
`else
    logic scl_unused;
    assign scl_unused = scl_i;
    assign stall      = 1'b0;
`endif

    assign tick = (cnt_q == 16'd0);

    always_comb begin
        unique case (state_q)
            S_DEVW:  byte_next = S_REG;
            S_REG:   byte_next = rw_q ? S_RSTART : S_WDATA;
            S_DEVR:  byte_next = S_RDATA;
            default: byte_next = S_STOP;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        qtr_d       = qtr_q;
        bit_d       = bit_q;
        cnt_d       = cnt_q;
        rw_d        = rw_q;
        dev_d       = dev_q;
        reg_d       = reg_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        nack_d      = nack_q;
        busy_d      = busy_q;
        rsp_valid_d = 1'b0;

        if (state_q == S_IDLE) begin
            cnt_d = CNT_MAX;
            if (cmd_valid && cmd_ready_q) begin
                rw_d    = cmd_rw;
                dev_d   = cmd_dev;
                reg_d   = cmd_reg;
                wdata_d = cmd_wdata;
                rdata_d = 8'h00;
                nack_d  = 1'b0;
                busy_d  = 1'b1;
                state_d = S_START;
                qtr_d   = 3'd0;
                bit_d   = 4'd0;
            end
        end else if (stall) begin
            cnt_d = cnt_q;
        end else if (!tick) begin
            cnt_d = cnt_q - 16'd1;
        end else begin
            cnt_d = CNT_MAX;
            unique case (state_q)
                S_START: begin
                    if (qtr_q == 3'd2) begin
                        state_d = S_DEVW;
                        qtr_d   = 3'd0;
                        bit_d   = 4'd0;
                    end else begin
                        qtr_d = qtr_q + 3'd1;
                    end
                end
                S_RSTART: begin
                    if (qtr_q == 3'd3) begin
                        state_d = S_DEVR;
                        qtr_d   = 3'd0;
                        bit_d   = 4'd0;
                    end else begin
                        qtr_d = qtr_q + 3'd1;
                    end
                end
                S_STOP: begin
                    if (qtr_q == 3'd5) begin
                        state_d     = S_IDLE;
                        qtr_d       = 3'd0;
                        busy_d      = 1'b0;
                        rsp_valid_d = 1'b1;
                    end else begin
                        qtr_d = qtr_q + 3'd1;
                    end
                end
                S_DEVW, S_REG, S_WDATA, S_DEVR, S_RDATA: begin
                    // q2->q3 boundary is the sampling point of every bit
                    if (qtr_q == 3'd2) begin
                        if (bit_q == 4'd8) begin
                            if (state_q != S_RDATA && sda_i)
                                nack_d = 1'b1;
                        end else if (state_q == S_RDATA) begin
                            rdata_d = {rdata_q[6:0], sda_i};
                        end
                    end
                    if (qtr_q == 3'd3) begin
                        qtr_d = 3'd0;
                        if (bit_q == 4'd8) begin
                            bit_d   = 4'd0;
                            state_d = nack_q ? S_STOP : byte_next;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end else begin
                        qtr_d = qtr_q + 3'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // Pad drive is derived from the next state so it is registered
    // alongside the state and changes only on quarter boundaries.
    always_comb begin
        unique case (state_d)
            S_DEVW:  tx_byte = {dev_q, 1'b0};
            S_REG:   tx_byte = reg_q;
            S_WDATA: tx_byte = wdata_q;
            S_DEVR:  tx_byte = {dev_q, 1'b1};
            default: tx_byte = 8'hFF;
        endcase
        tx_bit = tx_byte[3'd7 - bit_d[2:0]];

        unique case (state_d)
            S_START: begin
                scl_oeb_d = 1'b1;
                sda_oeb_d = (qtr_d == 3'd0);
            end
            S_RSTART: begin
                scl_oeb_d = (qtr_d != 3'd0);
                sda_oeb_d = (qtr_d < 3'd2);
            end
            S_STOP: begin
                scl_oeb_d = (qtr_d != 3'd0);
                sda_oeb_d = (qtr_d >= 3'd2);
            end
            S_DEVW, S_REG, S_WDATA, S_DEVR, S_RDATA: begin
                scl_oeb_d = qtr_d[1];
                if (bit_d == 4'd8 || state_d == S_RDATA)
                    sda_oeb_d = 1'b1;
                else
                    sda_oeb_d = tx_bit;
            end
            default: begin
                scl_oeb_d = 1'b1;
                sda_oeb_d = 1'b1;
            end
        endcase

        cmd_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= S_IDLE;
            qtr_q       <= 3'd0;
            bit_q       <= 4'd0;
            cnt_q       <= CNT_MAX;
            rw_q        <= 1'b0;
            dev_q       <= 7'd0;
            reg_q       <= 8'd0;
            wdata_q     <= 8'd0;
            rdata_q     <= 8'd0;
            nack_q      <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b0;
            scl_oeb_q   <= 1'b1;
            sda_oeb_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            qtr_q       <= qtr_d;
            bit_q       <= bit_d;
            cnt_q       <= cnt_d;
            rw_q        <= rw_d;
            dev_q       <= dev_d;
            reg_q       <= reg_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            nack_q      <= nack_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            cmd_ready_q <= cmd_ready_d;
            scl_oeb_q   <= scl_oeb_d;
            sda_oeb_q   <= sda_oeb_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_nack  = nack_q;
    assign busy      = busy_q;
    assign scl_oeb   = scl_oeb_q;
    assign sda_oeb   = sda_oeb_q;

endmodule
